tensor_pingpong_ctrl: RTL and testbench

- Sequences two external 1024 x int8 tensor RAM banks (1-write/1-read, registered read) as a ping-pong buffer.
- Video-side producer: the downscaler/quantiser streams one 32x32 int8 tensor per frame into the free bank.
- Inference engine reads a completed tensor by random address, then releases it. Writing and reading overlap across banks.
- Sits between the preprocessing pipeline and the CNN engine. Owns all bank write enables, address muxing and bank-full bookkeeping.

---
 rtl/tensor_pingpong_if.sv | 38 +++
 rtl/tensor_pingpong_ctrl.sv | 136 +++++++++++++
 tb/tb_tensor_pingpong_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/tensor_pingpong_if.sv
// Producer, RAM-bank and consumer signals of the ping-pong tensor controller.
// Data is two's-complement int8 carried as raw bits; the controller never does arithmetic on it.
interface tensor_pingpong_if #(
   parameter int AW = 10,
   parameter int DW = 8
);
   logic          s_valid;
   logic          s_sof;
   logic [DW-1:0] s_data;
   logic [1:0]    ram_we;
   logic [AW-1:0] ram_waddr;
   logic [DW-1:0] ram_wdata;
   logic [AW-1:0] ram_raddr;
   logic [DW-1:0] ram_rdata0;
   logic [DW-1:0] ram_rdata1;
   logic          t_valid;
   logic          t_bank;
   logic          c_req;
   logic [AW-1:0] c_addr;
   logic          c_rvalid;
   logic [DW-1:0] c_rdata;
   logic          c_done;
   logic          frame_drop;
   logic          frame_err;
   logic [15:0]   drop_cnt;

   modport slave (
      input  s_valid, s_sof, s_data, ram_rdata0, ram_rdata1, c_req, c_addr, c_done,
      output ram_we, ram_waddr, ram_wdata, ram_raddr, t_valid, t_bank,
             c_rvalid, c_rdata, frame_drop, frame_err, drop_cnt
   );

   modport master (
      output s_valid, s_sof, s_data, ram_rdata0, ram_rdata1, c_req, c_addr, c_done,
      input  ram_we, ram_waddr, ram_wdata, ram_raddr, t_valid, t_bank,
             c_rvalid, c_rdata, frame_drop, frame_err, drop_cnt
   );
endinterface

// File: rtl/tensor_pingpong_ctrl.sv
// Ping-pong sequencer for two 1W/1R tensor banks: producer fills the free bank, consumer reads the full one.
// Writes are combinational pass-through, reads return 1 cycle after c_req; producer is never stalled, frames drop.
module tensor_pingpong_ctrl #(
   parameter int DEPTH = 1024,
   parameter int AW    = 10,
   parameter int DW    = 8
) (
   input  logic              clk,
   input  logic              rst,
   tensor_pingpong_if.slave  bus
);
   typedef enum logic [1:0] {W_SYNC, W_FILL, W_SKIP} wstate_e;

   wstate_e       state_q, state_d;
   logic [1:0]    full_q, full_d;
   logic          wbank_q, wbank_d;
   logic          rbank_q, rbank_d;
   logic [AW-1:0] waddr_q, waddr_d;
   logic [15:0]   drop_cnt_q, drop_cnt_d;
   logic          frame_drop_q, frame_drop_d;
   logic          frame_err_q, frame_err_d;
   logic          c_rvalid_q, c_rvalid_d;
   logic          rd_bank_q, rd_bank_d;

   logic          sof_beat;
   logic          wr_en;
   logic          wr_last;
   logic [AW-1:0] wr_addr;
   logic          t_valid;
   logic [DW-1:0] rdata_mux;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= W_SYNC;
         full_q       <= '0;
         wbank_q      <= 1'b0;
         rbank_q      <= 1'b0;
         waddr_q      <= '0;
         drop_cnt_q   <= '0;
         frame_drop_q <= 1'b0;
         frame_err_q  <= 1'b0;
         c_rvalid_q   <= 1'b0;
         rd_bank_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         full_q       <= full_d;
         wbank_q      <= wbank_d;
         rbank_q      <= rbank_d;
         waddr_q      <= waddr_d;
         drop_cnt_q   <= drop_cnt_d;
         frame_drop_q <= frame_drop_d;
         frame_err_q  <= frame_err_d;
         c_rvalid_q   <= c_rvalid_d;
         rd_bank_q    <= rd_bank_d;
      end
   end

   // Output process: which beat is written this cycle and where.
   always_comb begin
      sof_beat = bus.s_valid & bus.s_sof;
      wr_en    = 1'b0;
      wr_addr  = waddr_q;
      case (state_q)
         W_FILL: begin
            wr_en = bus.s_valid;
            if (sof_beat) wr_addr = '0;
         end
         default: begin
            if (sof_beat && !full_q[wbank_q]) begin
               wr_en   = 1'b1;
               wr_addr = '0;
            end
         end
      endcase
      wr_last = wr_en && (wr_addr == AW'(DEPTH - 1));
   end

   always_comb begin
      state_d      = state_q;
      full_d       = full_q;
      wbank_d      = wbank_q;
      rbank_d      = rbank_q;
      waddr_d      = waddr_q;
      drop_cnt_d   = drop_cnt_q;
      frame_drop_d = 1'b0;
      frame_err_d  = 1'b0;

      case (state_q)
         W_FILL: frame_err_d = sof_beat;
         default: begin
            // W_SYNC and W_SKIP judge a sof identically; only a W_FILL sof restarts in place.
            if (sof_beat) begin
               if (full_q[wbank_q]) begin
                  frame_drop_d = 1'b1;
                  if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
                  state_d = W_SKIP;
               end else begin
                  state_d = W_FILL;
               end
            end
         end
      endcase

      if (wr_en) waddr_d = wr_addr + AW'(1);
      if (wr_last) begin
         full_d[wbank_q] = 1'b1;
         wbank_d         = ~wbank_q;
         waddr_d         = '0;
         state_d         = W_SYNC;
      end

      // A full read bank can never be the write target, so this never collides with wr_last.
      if (bus.c_done && t_valid) begin
         full_d[rbank_q] = 1'b0;
         rbank_d         = ~rbank_q;
      end

      c_rvalid_d = bus.c_req & t_valid;
      rd_bank_d  = rbank_q;
   end

   assign t_valid   = full_q[rbank_q];
   assign rdata_mux = rd_bank_q ? bus.ram_rdata1 : bus.ram_rdata0;

   assign bus.ram_we     = wr_en ? (wbank_q ? 2'b10 : 2'b01) : 2'b00;
   assign bus.ram_waddr  = wr_addr;
   assign bus.ram_wdata  = bus.s_data;
   assign bus.ram_raddr  = bus.c_addr;
   assign bus.t_valid    = t_valid;
   assign bus.t_bank     = rbank_q;
   assign bus.c_rvalid   = c_rvalid_q;
   assign bus.c_rdata    = c_rvalid_q ? rdata_mux : '0;
   assign bus.frame_drop = frame_drop_q;
   assign bus.frame_err  = frame_err_q;
   assign bus.drop_cnt   = drop_cnt_q;
endmodule

// File: tb/tb_tensor_pingpong_ctrl.sv
// Directed bench for tensor_pingpong_ctrl with a behavioural pair of registered-read banks.
module tb_tensor_pingpong_ctrl;
   localparam int DEPTH = 1024;
   localparam int AW    = 10;
   localparam int DW    = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   tensor_pingpong_if #(.AW(AW), .DW(DW)) bus ();

   tensor_pingpong_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [DW-1:0] mem0 [0:DEPTH-1];
   logic [DW-1:0] mem1 [0:DEPTH-1];

   always @(posedge clk) begin
      if (bus.ram_we[0]) mem0[bus.ram_waddr] <= bus.ram_wdata;
      if (bus.ram_we[1]) mem1[bus.ram_waddr] <= bus.ram_wdata;
      bus.ram_rdata0 <= mem0[bus.ram_raddr];
      bus.ram_rdata1 <= mem1[bus.ram_raddr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle of stimulus; returns mid-cycle so comb outputs can be sampled.
   task automatic cyc(input bit v, input bit s, input logic [7:0] d,
                      input bit req, input int addr, input bit done);
      @(posedge clk);
      #1;
      bus.s_valid = v;
      bus.s_sof   = s;
      bus.s_data  = d;
      bus.c_req   = req;
      bus.c_addr  = AW'(addr);
      bus.c_done  = done;
      #3;
   endtask

   task automatic fill(input string tag, input int n, input bit sof_first, input logic [1:0] we,
                       input int start, input int seed);
      int bad;
      int tmp;
      bad = 0;
      for (int i = 0; i < n; i++) begin
         tmp = start + i + seed;
         cyc(1'b1, sof_first && (i == 0), tmp[7:0], 1'b0, 0, 1'b0);
         if (bus.ram_we !== we || bus.ram_waddr !== AW'(start + i) || bus.ram_wdata !== tmp[7:0])
            bad++;
      end
      chk(tag, bad, 0);
   endtask

   initial begin
      bus.s_valid = 1'b0;
      bus.s_sof   = 1'b0;
      bus.s_data  = '0;
      bus.c_req   = 1'b0;
      bus.c_addr  = '0;
      bus.c_done  = 1'b0;
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      #4;
      chk("rst_t_valid", bus.t_valid, 0);
      chk("rst_t_bank", bus.t_bank, 0);
      chk("rst_ram_we", bus.ram_we, 0);
      chk("rst_c_rvalid", bus.c_rvalid, 0);
      chk("rst_c_rdata", bus.c_rdata, 0);
      chk("rst_pulses", {bus.frame_drop, bus.frame_err}, 0);
      chk("rst_drop_cnt", bus.drop_cnt, 0);
      @(posedge clk);
      #1 rst = 1'b0;

      // First tensor into bank 0, data = addr[7:0]
      fill("fill_b0", 1024, 1'b1, 2'b01, 0, 0);
      chk("tv_last_beat", bus.t_valid, 0);
      cyc(0, 0, 8'h00, 0, 0, 0);
      chk("tv_after_fill", bus.t_valid, 1);
      chk("tb_after_fill", bus.t_bank, 0);

      // Random reads from bank 0
      cyc(0, 0, 8'h00, 1, 5, 0);
      chk("rvalid_req_cycle", bus.c_rvalid, 0);
      cyc(0, 0, 8'h00, 1, 1023, 0);
      chk("rvalid_a5", bus.c_rvalid, 1);
      chk("rdata_a5", bus.c_rdata, 8'h05);
      cyc(0, 0, 8'h00, 0, 0, 0);
      chk("rdata_a1023", bus.c_rdata, 8'hFF);
      cyc(0, 0, 8'h00, 0, 0, 0);
      chk("rvalid_idle", bus.c_rvalid, 0);

      // Bank 1 fill overlapped with a bank 0 read
      fill("fill_b1_lo", 512, 1'b1, 2'b10, 0, 8'h40);
      cyc(1, 0, 8'h40, 1, 7, 0);
      chk("ovl_we", bus.ram_we, 2'b10);
      chk("ovl_waddr", bus.ram_waddr, 512);
      cyc(1, 0, 8'h41, 0, 0, 0);
      chk("ovl_rvalid", bus.c_rvalid, 1);
      chk("ovl_rdata", bus.c_rdata, 8'h07);
      fill("fill_b1_hi", 510, 1'b0, 2'b10, 514, 8'h40);
      cyc(0, 0, 8'h00, 0, 0, 0);
      chk("both_full_tv", bus.t_valid, 1);
      chk("both_full_tb", bus.t_bank, 0);

      // Third frame with both banks full is dropped
      cyc(1, 1, 8'h99, 0, 0, 0);
      chk("drop_no_we", bus.ram_we, 0);
      cyc(1, 0, 8'h01, 0, 0, 0);
      chk("drop_pulse", bus.frame_drop, 1);
      chk("drop_cnt1", bus.drop_cnt, 1);
      chk("skip_no_we", bus.ram_we, 0);
      cyc(1, 0, 8'h02, 0, 0, 0);
      chk("drop_pulse_end", bus.frame_drop, 0);

      // sof together with c_done: still dropped; same-cycle read served from old bank
      cyc(1, 1, 8'h98, 1, 9, 1);
      chk("sof_done_no_we", bus.ram_we, 0);
      cyc(0, 0, 8'h00, 0, 0, 0);
      chk("drop2_pulse", bus.frame_drop, 1);
      chk("drop_cnt2", bus.drop_cnt, 2);
      chk("rel_tb", bus.t_bank, 1);
      chk("rel_tv", bus.t_valid, 1);
      chk("rel_rvalid", bus.c_rvalid, 1);
      chk("rel_rdata_old", bus.c_rdata, 8'h09);

      // Next sof goes to the freed bank 0
      fill("fill_b0_again", 1024, 1'b1, 2'b01, 0, 8'h80);
      cyc(0, 0, 8'h00, 0, 0, 0);
      chk("refill_tb", bus.t_bank, 1);
      chk("refill_cnt", bus.drop_cnt, 2);

      // Release bank 1, read back refilled bank 0
      cyc(0, 0, 8'h00, 0, 0, 1);
      cyc(0, 0, 8'h00, 1, 3, 0);
      chk("rel1_tb", bus.t_bank, 0);
      chk("rel1_tv", bus.t_valid, 1);
      cyc(0, 0, 8'h00, 0, 0, 0);
      chk("b0_refill_rdata", bus.c_rdata, 8'h83);

      // sof at waddr 300 restarts the bank 1 fill
      fill("fill_b1_part", 300, 1'b1, 2'b10, 0, 8'h11);
      cyc(1, 1, 8'h22, 0, 0, 0);
      chk("err_we", bus.ram_we, 2'b10);
      chk("err_waddr0", bus.ram_waddr, 0);
      cyc(1, 0, 8'h23, 0, 0, 0);
      chk("err_pulse", bus.frame_err, 1);
      chk("err_waddr1", bus.ram_waddr, 1);
      fill("fill_b1_restart", 1022, 1'b0, 2'b10, 2, 8'h22);
      cyc(0, 0, 8'h00, 0, 0, 0);
      chk("err_pulse_end", bus.frame_err, 0);
      cyc(0, 0, 8'h00, 0, 0, 1);
      cyc(0, 0, 8'h00, 1, 0, 0);
      chk("b1_done_tb", bus.t_bank, 1);
      chk("b1_done_tv", bus.t_valid, 1);
      cyc(0, 0, 8'h00, 1, 1023, 0);
      chk("b1_rdata0", bus.c_rdata, 8'h22);
      cyc(0, 0, 8'h00, 0, 0, 0);
      chk("b1_rdata1023", bus.c_rdata, 8'h21);

      // Async reset mid-fill of bank 0 while bank 1 is presented
      fill("fill_b0_part", 500, 1'b1, 2'b01, 0, 8'h33);
      chk("pre_rst_tv", bus.t_valid, 1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_tv", bus.t_valid, 0);
      chk("async_rst_tb", bus.t_bank, 0);
      chk("async_rst_we", bus.ram_we, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      cyc(0, 0, 8'h00, 1, 3, 1);
      cyc(0, 0, 8'h00, 0, 0, 0);
      chk("ign_rvalid", bus.c_rvalid, 0);
      chk("ign_done_tb", bus.t_bank, 0);
      chk("post_rst_cnt", bus.drop_cnt, 0);
      fill("fill_post_rst", 1024, 1'b1, 2'b01, 0, 8'h44);
      cyc(0, 0, 8'h00, 0, 0, 0);
      chk("post_rst_tv", bus.t_valid, 1);
      chk("post_rst_tb", bus.t_bank, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
